// File: rtl/calc_mvd_cost_mul_arbiter.sv
// Two-requester round-robin front end for a shared pipelined multiplier.
// A valid/tag tracker shadows the multiplier pipeline so each product returns with its owner.
module calc_mvd_cost_mul_arbiter #(
  parameter int MUL_LATENCY = 4,
  parameter int DIN0_WIDTH  = 41,
  parameter int DIN1_WIDTH  = 64,
  parameter int DOUT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DIN0_WIDTH-1:0] req0_a,
  input  logic [DIN1_WIDTH-1:0] req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DIN0_WIDTH-1:0] req1_a,
  input  logic [DIN1_WIDTH-1:0] req1_b,
  output logic                  mul_ce,
  output logic [DIN0_WIDTH-1:0] mul_din0,
  output logic [DIN1_WIDTH-1:0] mul_din1,
  input  logic [DOUT_WIDTH-1:0] mul_dout,
  output logic                  res_valid,
  output logic                  res_id,
  output logic [DOUT_WIDTH-1:0] res_data,
  input  logic                  res_ready,
  output logic                  busy
);

  // Bit i of the tracker corresponds to multiplier stage i+1.
  logic [MUL_LATENCY-1:0] vld_p;
  logic [MUL_LATENCY-1:0] tag_p;
  logic                   last_served;
  logic                   gnt_any;
  logic                   gnt_id;
  logic                   accept;

  always_comb begin
    mul_ce     = !(vld_p[MUL_LATENCY-1] && !res_ready);
    gnt_any    = !reset && (req0_valid || req1_valid);
    gnt_id     = (req0_valid && req1_valid) ? !last_served : req1_valid;
    accept     = gnt_any && mul_ce;
    req0_ready = accept && !gnt_id;
    req1_ready = accept && gnt_id;
    mul_din0   = '0;
    mul_din1   = '0;
    if (gnt_any) begin
      mul_din0 = gnt_id ? req1_a : req0_a;
      mul_din1 = gnt_id ? req1_b : req0_b;
    end
  end

  // Tracker advances in lockstep with the multiplier clock enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p       <= '0;
      tag_p       <= '0;
      last_served <= 1'b1;
    end else if (mul_ce) begin
      vld_p[0] <= accept;
      tag_p[0] <= accept && gnt_id;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        tag_p[i] <= tag_p[i-1];
      end
      if (accept) last_served <= gnt_id;
    end
  end

  assign res_valid = vld_p[MUL_LATENCY-1];
  assign res_id    = tag_p[MUL_LATENCY-1];
  assign res_data  = mul_dout;
  assign busy      = |vld_p;

endmodule

// File: tb/tb_calc_mvd_cost_mul_arbiter.sv
// Bench for calc_mvd_cost_mul_arbiter: behavioural multiplier plus a queue-based
// reference model of arbitration, latency and back-pressure.
module tb_calc_mvd_cost_mul_arbiter;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [40:0] req0_a, req1_a;
  logic [63:0] req0_b, req1_b;
  logic        mul_ce;
  logic [40:0] mul_din0;
  logic [63:0] mul_din1, mul_dout, res_data;
  logic        res_valid, res_id, res_ready, busy;

  int errors = 0;
  int checks = 0;

  calc_mvd_cost_mul_arbiter #(.MUL_LATENCY(L), .DIN0_WIDTH(41), .DIN1_WIDTH(64), .DOUT_WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .res_ready(res_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared multiplier: L-stage pipeline, no reset, so stale products linger.
  logic [63:0] mpipe [L];
  always @(posedge clk) begin
    if (mul_ce) begin
      mpipe[0] <= 64'($signed({1'b0, mul_din0}) * $signed(mul_din1));
      for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_dout = mpipe[L-1];

  // Reference model: in-flight ops kept in issue order with their age in enabled edges.
  typedef struct { bit id; logic [63:0] data; int age; } ent_t;
  ent_t q[$];
  bit   ptr;

  function automatic bit m_head(); return (q.size() > 0) && (q[0].age == L); endfunction
  function automatic bit m_ce();   return !(m_head() && !res_ready); endfunction
  function automatic bit m_gany(); return !reset && (req0_valid || req1_valid); endfunction
  function automatic bit m_gid();  return (req0_valid && req1_valid) ? !ptr : req1_valid; endfunction

  function automatic logic [174:0] model_exp();
    logic [40:0] d0;
    logic [63:0] d1;
    bit g  = m_gany();
    bit gi = m_gid();
    bit ce = m_ce();
    bit hv = m_head();
    d0 = g ? (gi ? req1_a : req0_a) : 41'd0;
    d1 = g ? (gi ? req1_b : req0_b) : 64'd0;
    return {g & ce & !gi, g & ce & gi, ce, hv, hv ? q[0].id : 1'b0, q.size() != 0,
            hv ? q[0].data : 64'd0, d0, d1};
  endfunction

  function automatic logic [174:0] observe();
    return {req0_ready, req1_ready, mul_ce, res_valid, res_id, busy,
            res_valid ? res_data : 64'd0, mul_din0, mul_din1};
  endfunction

  function automatic logic [63:0] prod(input logic [40:0] a, input logic [63:0] b);
    return 64'(a) * b;
  endfunction

  task automatic model_advance();
    bit g  = m_gany();
    bit gi = m_gid();
    bit ce = m_ce();
    bit hv = m_head();
    if (reset || !ce) return;
    if (hv) void'(q.pop_front());
    foreach (q[i]) q[i].age++;
    if (g) begin
      ent_t e;
      e.id   = gi;
      e.data = gi ? prod(req1_a, req1_b) : prod(req0_a, req0_b);
      e.age  = 1;
      q.push_back(e);
      ptr = gi;
    end
  endtask

  task automatic model_reset();
    q.delete();
    ptr = 1'b1;
  endtask

  task automatic drive(input bit v0, input logic [40:0] a0, input logic [63:0] b0,
                       input bit v1, input logic [40:0] a1, input logic [63:0] b1, input bit rr);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    res_ready  = rr;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  logic [174:0] exp_v, obs_v;

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    drive(1, 41'd5, 64'd7, 1, 41'd6, 64'd8, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (observe() !== {3'b001, 172'd0}) begin
        errors++;
        $display("FAIL reset_state cyc %0d: got %h want %h", i, observe(), {3'b001, 172'd0});
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    exp_v = model_exp(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL reset_release: got %h want %h", obs_v, exp_v); end
    model_advance();
    @(posedge clk); #1;
  endtask

  task automatic test_single_op();
    int lat = -1;
    logic got_id;
    logic [63:0] got_d;
    drive(1, 41'd3, -64'sd5, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_v = model_exp(); obs_v = observe(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL single_op cyc %0d: got %h want %h", i, obs_v, exp_v); end
      if (res_valid && lat < 0) begin lat = i; got_id = res_id; got_d = res_data; end
      model_advance();
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 1);
    end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL single_op_latency: got %0d want 4", lat); end
    checks++;
    if (lat < 0 || got_id !== 1'b0 || got_d !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      errors++; $display("FAIL single_op_result: got id %b data %h want id 0 data fffffffffffffff1", got_id, got_d);
    end
  endtask

  task automatic test_contention();
    int acc[$];
    int rid[$];
    int rcy[$];
    logic [63:0] rdat[$];
    do_reset();
    drive(1, 41'd1, 64'd10, 1, 41'd2, 64'd20, 1);
    for (int i = 0; i < 18; i++) begin
      if (i == 12) drive(0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      exp_v = model_exp(); obs_v = observe(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL contention cyc %0d: got %h want %h", i, obs_v, exp_v); end
      if (req0_ready) acc.push_back(0);
      if (req1_ready) acc.push_back(1);
      if (res_valid && res_ready) begin rid.push_back(int'(res_id)); rdat.push_back(res_data); rcy.push_back(i); end
      model_advance();
      @(posedge clk); #1;
    end
    checks++;
    if (acc.size() != 12 || rid.size() != 12) begin
      errors++; $display("FAIL contention_counts: got acc %0d res %0d want 12 12", acc.size(), rid.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (acc[k] != k % 2 || rid[k] != k % 2 || rdat[k] !== ((k % 2) ? 64'd40 : 64'd10) || rcy[k] != rcy[0] + k) begin
          errors++;
          $display("FAIL contention_seq %0d: got acc %0d id %0d data %0d cyc %0d want %0d %0d %0d %0d",
                   k, acc[k], rid[k], rdat[k], rcy[k], k % 2, k % 2, (k % 2) ? 40 : 10, rcy[0] + k);
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [63:0] sb[$];
    logic [63:0] held;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      drive(i < 20, 41'({$urandom, $urandom}), {$urandom, $urandom},
            i < 20, 41'({$urandom, $urandom}), {$urandom, $urandom}, !(i >= 6 && i < 12));
      @(negedge clk);
      exp_v = model_exp(); obs_v = observe(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL back_pressure cyc %0d: got %h want %h", i, obs_v, exp_v); end
      if (i == 6) held = res_data;
      if (i >= 6 && i < 12) begin
        checks++;
        if (mul_ce !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== held) begin
          errors++;
          $display("FAIL stall cyc %0d: got ce %b rdy %b%b vld %b data %h want 0 00 1 %h",
                   i, mul_ce, req0_ready, req1_ready, res_valid, res_data, held);
        end
      end
      if (req0_valid && req0_ready) sb.push_back(prod(req0_a, req0_b));
      if (req1_valid && req1_ready) sb.push_back(prod(req1_a, req1_b));
      if (res_valid && res_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL bp_order: got extra result %h want none", res_data);
        end else if (res_data !== sb[0]) begin
          errors++; $display("FAIL bp_order: got %h want %h", res_data, sb[0]);
          void'(sb.pop_front());
        end else void'(sb.pop_front());
      end
      model_advance();
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL bp_lost: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_extremes();
    logic [63:0] r[$];
    for (int i = 0; i < 8; i++) begin
      if (i == 0) drive(1, 41'h1FF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1);
      else if (i == 1) drive(1, 41'd0, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 0, 1);
      else drive(0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      exp_v = model_exp(); obs_v = observe(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL extremes cyc %0d: got %h want %h", i, obs_v, exp_v); end
      if (res_valid) r.push_back(res_data);
      model_advance();
      @(posedge clk); #1;
    end
    checks++;
    if (r.size() != 2 || r[0] !== 64'hFFFF_FE00_0000_0001 || r[1] !== 64'd0) begin
      errors++; $display("FAIL extremes_values: got n=%0d want 2 results fffffe0000000001, 0", r.size());
    end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1, 41'(i + 1), 64'd7, 0, 0, 0, 0);
      else drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      exp_v = model_exp(); obs_v = observe(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL midflight_fill cyc %0d: got %h want %h", i, obs_v, exp_v); end
      model_advance();
      @(posedge clk); #1;
    end
    checks++;
    if (res_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL midflight_pre: got vld %b busy %b want 1 1", res_valid, busy);
    end
    #1 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midflight_async: got vld %b busy %b want 0 0", res_valid, busy);
    end
    #1 reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_v = model_exp(); obs_v = observe(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL midflight_drain cyc %0d: got %h want %h", i, obs_v, exp_v); end
      if (res_valid) seen++;
      model_advance();
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midflight_stale: got %0d results want 0", seen); end
    drive(1, 41'd9, 64'd9, 1, 41'd8, 64'd8, 1);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL midflight_tie: got rdy %b%b want 10", req0_ready, req1_ready);
    end
    model_advance();
    @(posedge clk); #1;
  endtask

  task automatic test_streaming();
    logic [63:0] sent[$];
    int n = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) drive(0, 0, 0, 1, 41'({$urandom, $urandom}), {$urandom, $urandom}, 1);
      else drive(0, 0, 0, 0, 0, 0, 1);
      if (i < 8) sent.push_back(prod(req1_a, req1_b));
      @(negedge clk);
      exp_v = model_exp(); obs_v = observe(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL streaming cyc %0d: got %h want %h", i, obs_v, exp_v); end
      if (res_valid && res_id === 1'b1) begin
        checks++;
        if (n >= 8 || res_data !== sent[n]) begin
          errors++; $display("FAIL streaming_data %0d: got %h want %h", n, res_data, (n < 8) ? sent[n] : 64'd0);
        end
        n++;
      end
      model_advance();
      @(posedge clk); #1;
    end
    checks++;
    if (n != 8) begin errors++; $display("FAIL streaming_count: got %0d want 8", n); end
    drive(1, 41'd1, 64'd1, 1, 41'd1, 64'd1, 1);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL streaming_tie: got rdy %b%b want 10", req0_ready, req1_ready);
    end
    model_advance();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), 41'({$urandom, $urandom}), {$urandom, $urandom},
            $urandom_range(0, 1), 41'({$urandom, $urandom}), {$urandom, $urandom},
            $urandom_range(0, 9) < 7);
      @(negedge clk);
      exp_v = model_exp(); obs_v = observe(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL random cyc %0d: got %h want %h", i, obs_v, exp_v); end
      model_advance();
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_back_pressure();
    test_extremes();
    test_reset_midflight();
    test_streaming();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
